// File: rtl/cube_pkg.sv
// Shared constants, face/colour encodings and colour conversion helpers
// for the cube drawer and the net decoder.
package cube_pkg;

    localparam int STICKER_SIZE = 8;
    localparam int STICKER_BITS = $clog2(STICKER_SIZE);
    localparam int FACE_SIZE    = 3 * STICKER_SIZE;
    localparam int NUM_STICKERS = 54;
    localparam int FRAME_PIXELS = NUM_STICKERS * STICKER_SIZE * STICKER_SIZE;
    localparam int PIX_CNT_W    = 12;

    typedef enum logic [2:0] {
        FACE_U = 3'd0,
        FACE_L = 3'd1,
        FACE_F = 3'd2,
        FACE_R = 3'd3,
        FACE_B = 3'd4,
        FACE_D = 3'd5
    } face_e;

    // Top-left corner of each face in the unfolded net
    localparam logic [7:0] U_X0 = 8'(FACE_SIZE);
    localparam logic [6:0] U_Y0 = 7'd0;
    localparam logic [7:0] L_X0 = 8'd0;
    localparam logic [6:0] L_Y0 = 7'(FACE_SIZE);
    localparam logic [7:0] F_X0 = 8'(FACE_SIZE);
    localparam logic [6:0] F_Y0 = 7'(FACE_SIZE);
    localparam logic [7:0] R_X0 = 8'(2 * FACE_SIZE);
    localparam logic [6:0] R_Y0 = 7'(FACE_SIZE);
    localparam logic [7:0] B_X0 = 8'(3 * FACE_SIZE);
    localparam logic [6:0] B_Y0 = 7'(FACE_SIZE);
    localparam logic [7:0] D_X0 = 8'(FACE_SIZE);
    localparam logic [6:0] D_Y0 = 7'(2 * FACE_SIZE);

    localparam logic [2:0] RGB_RED    = 3'b100;
    localparam logic [2:0] RGB_GREEN  = 3'b010;
    localparam logic [2:0] RGB_BLUE   = 3'b001;
    localparam logic [2:0] RGB_YELLOW = 3'b110;
    localparam logic [2:0] RGB_CYAN   = 3'b011;
    localparam logic [2:0] RGB_WHITE  = 3'b111;
    localparam logic [2:0] ID_UNKNOWN = 3'd7;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_e;

    function automatic logic [2:0] map_color(input logic [2:0] id);
        case (id)
            3'd0:    return RGB_RED;
            3'd1:    return RGB_GREEN;
            3'd2:    return RGB_BLUE;
            3'd3:    return RGB_YELLOW;
            3'd4:    return RGB_CYAN;
            3'd5:    return RGB_WHITE;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] unmap_color(input logic [2:0] rgb);
        case (rgb)
            RGB_RED:    return 3'd0;
            RGB_GREEN:  return 3'd1;
            RGB_BLUE:   return 3'd2;
            RGB_YELLOW: return 3'd3;
            RGB_CYAN:   return 3'd4;
            RGB_WHITE:  return 3'd5;
            default:    return ID_UNKNOWN;
        endcase
    endfunction

endpackage

// File: rtl/cube_pixel_locator.sv
// Maps a net pixel coordinate to its sticker index and position inside
// that sticker, using range compares and shifts only.
module cube_pixel_locator
    import cube_pkg::*;
(
    input  logic [7:0]              x,
    input  logic [6:0]              y,
    output logic                    on_net,
    output logic [5:0]              sticker,
    output logic [STICKER_BITS-1:0] local_x,
    output logic [STICKER_BITS-1:0] local_y
);

    logic [2:0] col;
    logic [1:0] row;
    logic [7:0] off_x;
    logic [6:0] off_y;
    logic [5:0] sx;
    logic [5:0] sy;
    face_e      face;

    // Column/row of the face grid; col 4 / row 3 mean outside the grid
    always_comb begin
        col   = 3'd4;
        off_x = x;
        if (x < 8'(FACE_SIZE)) begin
            col = 3'd0;
        end else if (x < 8'(2 * FACE_SIZE)) begin
            col   = 3'd1;
            off_x = x - 8'(FACE_SIZE);
        end else if (x < 8'(3 * FACE_SIZE)) begin
            col   = 3'd2;
            off_x = x - 8'(2 * FACE_SIZE);
        end else if (x < 8'(4 * FACE_SIZE)) begin
            col   = 3'd3;
            off_x = x - 8'(3 * FACE_SIZE);
        end
    end

    always_comb begin
        row   = 2'd3;
        off_y = y;
        if (y < 7'(FACE_SIZE)) begin
            row = 2'd0;
        end else if (y < 7'(2 * FACE_SIZE)) begin
            row   = 2'd1;
            off_y = y - 7'(FACE_SIZE);
        end else if (y < 7'(3 * FACE_SIZE)) begin
            row   = 2'd2;
            off_y = y - 7'(2 * FACE_SIZE);
        end
    end

    always_comb begin
        on_net = 1'b1;
        face   = FACE_U;
        if (row == 2'd0 && col == 3'd1)      face = FACE_U;
        else if (row == 2'd1 && col == 3'd0) face = FACE_L;
        else if (row == 2'd1 && col == 3'd1) face = FACE_F;
        else if (row == 2'd1 && col == 3'd2) face = FACE_R;
        else if (row == 2'd1 && col == 3'd3) face = FACE_B;
        else if (row == 2'd2 && col == 3'd1) face = FACE_D;
        else                                 on_net = 1'b0;
    end

    assign sx      = 6'(off_x >> STICKER_BITS);
    assign sy      = 6'(off_y >> STICKER_BITS);
    assign local_x = off_x[STICKER_BITS-1:0];
    assign local_y = off_y[STICKER_BITS-1:0];
    assign sticker = on_net ? (6'(face) * 6'd9 + sy * 6'd3 + sx) : 6'd0;

endmodule

// File: rtl/cube_net_decoder.sv
// Rebuilds the 54 sticker colour IDs from the drawn net pixel stream and
// commits them only when a whole frame arrived complete and consistent.
module cube_net_decoder
    import cube_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    input  logic       plot,
    output logic [2:0] colors [0:NUM_STICKERS-1],
    output logic       frame_done,
    output logic       frame_ok,
    output logic       valid
);

    logic [7:0] x_reg;
    logic [6:0] y_reg;
    logic [2:0] colour_reg;
    logic       plot_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_reg      <= '0;
            y_reg      <= '0;
            colour_reg <= '0;
            plot_reg   <= 1'b0;
        end else begin
            x_reg      <= x;
            y_reg      <= y;
            colour_reg <= colour;
            plot_reg   <= plot;
        end
    end

    logic                    on_net;
    logic [5:0]              loc_sticker;
    logic [STICKER_BITS-1:0] loc_x;
    logic [STICKER_BITS-1:0] loc_y;

    cube_pixel_locator u_locator (
        .x       (x_reg),
        .y       (y_reg),
        .on_net  (on_net),
        .sticker (loc_sticker),
        .local_x (loc_x),
        .local_y (loc_y)
    );

    logic [2:0] pix_id;
    logic       id_invalid;
    logic       px_live;
    logic       is_start;
    logic       is_end;

    assign pix_id     = unmap_color(colour_reg);
    assign id_invalid = (pix_id == ID_UNKNOWN);
    assign px_live    = plot_reg && on_net;
    assign is_start   = px_live && (loc_sticker == 6'd0) && (loc_x == '0) && (loc_y == '0);
    assign is_end     = px_live && (loc_sticker == 6'(NUM_STICKERS - 1)) && (&loc_x) && (&loc_y);

    state_e state_reg;
    state_e state_next;
    logic   clear_en;
    logic   proc_en;
    logic   eval_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (is_start)                                state_next = ST_CAPTURE;
        else if (state_reg == ST_CAPTURE && is_end)  state_next = ST_IDLE;
    end

    // The start pixel both restarts the capture and counts as its first pixel
    always_comb begin
        clear_en = is_start;
        proc_en  = px_live && (is_start || state_reg == ST_CAPTURE);
        eval_en  = (state_reg == ST_CAPTURE) && is_end;
    end

    logic [NUM_STICKERS-1:0] seen_reg;
    logic [NUM_STICKERS-1:0] seen_eff;
    logic [NUM_STICKERS-1:0] seen_next;
    logic [NUM_STICKERS-1:0] hit;
    logic [NUM_STICKERS-1:0] differ;
    logic [2:0]              shadow_reg  [0:NUM_STICKERS-1];
    logic [2:0]              shadow_next [0:NUM_STICKERS-1];
    logic [PIX_CNT_W-1:0]    pix_cnt_reg;
    logic [PIX_CNT_W-1:0]    pix_cnt_next;
    logic                    err_reg;
    logic                    err_next;
    logic                    frame_good;
    logic                    commit;

    assign seen_eff = clear_en ? '0 : seen_reg;

    for (genvar gi = 0; gi < NUM_STICKERS; gi++) begin : g_sticker
        assign hit[gi]         = proc_en && (loc_sticker == 6'(gi));
        assign differ[gi]      = (shadow_reg[gi] != pix_id);
        assign seen_next[gi]   = seen_eff[gi] | hit[gi];
        assign shadow_next[gi] = (hit[gi] && !seen_eff[gi]) ? pix_id : shadow_reg[gi];
    end

    always_comb begin
        pix_cnt_next = clear_en ? '0 : pix_cnt_reg;
        if (proc_en && pix_cnt_next != '1) pix_cnt_next = pix_cnt_next + 1'b1;
        err_next = (clear_en ? 1'b0 : err_reg)
                 | (proc_en && (id_invalid || (|(hit & seen_eff & differ))));
    end

    // Judged on the next-state values so the end pixel itself is included
    assign frame_good = !err_next && (pix_cnt_next == PIX_CNT_W'(FRAME_PIXELS)) && (&seen_next);
    assign commit     = eval_en && frame_good;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_cnt_reg <= '0;
            err_reg     <= 1'b0;
            seen_reg    <= '0;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
            valid       <= 1'b0;
            for (int i = 0; i < NUM_STICKERS; i++) begin
                shadow_reg[i] <= ID_UNKNOWN;
                colors[i]     <= ID_UNKNOWN;
            end
        end else begin
            pix_cnt_reg <= pix_cnt_next;
            err_reg     <= err_next;
            seen_reg    <= seen_next;
            frame_done  <= eval_en;
            if (eval_en) frame_ok <= frame_good;
            if (commit)  valid    <= 1'b1;
            for (int i = 0; i < NUM_STICKERS; i++) begin
                shadow_reg[i] <= shadow_next[i];
                if (commit) colors[i] <= shadow_next[i];
            end
        end
    end

endmodule

// File: tb/tb_cube_net_decoder.sv
// Drives drawer-order net frames with planted faults and checks every
// frame_done against a scoreboard of expected results.
`timescale 1ns/1ps
module tb_cube_net_decoder;

    localparam int SPIX     = 64;
    localparam int FPIX     = 3456;
    localparam int F_NONE   = 0;
    localparam int F_DROP   = 1;
    localparam int F_COLOR  = 2;
    localparam int F_DUP    = 3;
    localparam int F_OFFNET = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] x = '0;
    logic [6:0] y = '0;
    logic [2:0] colour = '0;
    logic       plot = 1'b0;
    logic [2:0] colors [0:53];
    logic       frame_done;
    logic       frame_ok;
    logic       valid;

    cube_net_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .colors     (colors),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .valid      (valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int              due;
        bit              ok;
        bit              vld;
        logic [53:0][2:0] cols;
        string           name;
    } exp_t;

    typedef struct {
        string      name;
        int         fault;
        int         fpos;
        int         fx;
        int         fy;
        logic [2:0] fcol;
        int         pat;
        bit         exp_ok;
    } vec_t;

    exp_t             sb[$];
    logic [53:0][2:0] model_cols;
    bit               model_valid = 1'b0;
    int               checks = 0;
    int               failures = 0;
    int               done_seen = 0;
    int               done_exp = 0;

    task automatic check(input bit pass, input string name, input int got, input int want);
        checks++;
        if (!pass) begin
            failures++;
            $display("FAIL %s: got=%0d required=%0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic int pat_id(input int p, input int s);
        case (p)
            0:       return s % 6;
            1:       return (s + 3) % 6;
            default: return 5 - (s % 6);
        endcase
    endfunction

    function automatic logic [2:0] rgb_of(input int id);
        case (id)
            0:       return 3'b100;
            1:       return 3'b010;
            2:       return 3'b001;
            3:       return 3'b110;
            4:       return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    function automatic int ox(input int f);
        case (f)
            0:       return 24;
            1:       return 0;
            2:       return 24;
            3:       return 48;
            4:       return 72;
            default: return 24;
        endcase
    endfunction

    function automatic int oy(input int f);
        case (f)
            0:       return 0;
            5:       return 48;
            default: return 24;
        endcase
    endfunction

    function automatic bit all_unknown();
        for (int i = 0; i < 54; i++) if (colors[i] !== 3'd7) return 1'b0;
        return 1'b1;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        int   bad;
        int   idx;
        if (!reset && frame_done) begin
            done_seen++;
            if (sb.size() == 0) begin
                check(1'b0, "spurious_frame_done frame_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check(cyc == e.due, {e.name, " done_cycle"}, cyc, e.due);
                check(frame_ok == e.ok, {e.name, " frame_ok"}, int'(frame_ok), int'(e.ok));
                check(valid == e.vld, {e.name, " valid"}, int'(valid), int'(e.vld));
                bad = -1;
                for (int i = 53; i >= 0; i--) if (colors[i] !== e.cols[i]) bad = i;
                idx = (bad < 0) ? 0 : bad;
                check(bad < 0, $sformatf("%s colors[%0d]", e.name, idx),
                      int'(colors[idx]), int'(e.cols[idx]));
                $display("frame %s: done at cycle %0d frame_ok=%0b valid=%0b",
                         e.name, cyc, frame_ok, valid);
            end
        end
    end

    task automatic drive(input logic [7:0] px, input logic [6:0] py,
                         input logic [2:0] c, input logic pl);
        x      = px;
        y      = py;
        colour = c;
        plot   = pl;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string name, input int pat, input bit ok);
        exp_t e;
        if (ok) begin
            for (int s = 0; s < 54; s++) model_cols[s] = 3'(pat_id(pat, s));
            model_valid = 1'b1;
        end
        e.due  = cyc + 2;
        e.ok   = ok;
        e.vld  = model_valid;
        e.cols = model_cols;
        e.name = name;
        sb.push_back(e);
        done_exp++;
    endtask

    task automatic send_frame(input string name, input int pat, input int fault, input int fpos,
                              input int fx, input int fy, input logic [2:0] fcol,
                              input int npix, input bit exp_ok);
        for (int i = 0; i < npix; i++) begin
            int         s;
            int         l;
            int         f;
            int         px;
            int         py;
            logic [2:0] c;
            logic       pl;
            s  = i / SPIX;
            l  = i % SPIX;
            f  = s / 9;
            px = ox(f) + ((s % 9) % 3) * 8 + (l % 8);
            py = oy(f) + ((s % 9) / 3) * 8 + (l / 8);
            c  = rgb_of(pat_id(pat, s));
            if (fault == F_COLOR && px == fx && py == fy) c = fcol;
            pl = !(fault == F_DROP && i == fpos);
            if (fault == F_OFFNET && (i % 7) == 3) begin
                drive(8'd100, 7'd100, 3'b000, 1'b1);
                drive(8'd0, 7'd0, 3'b000, 1'b1);
            end
            if (i == FPIX - 1 && npix == FPIX) push_exp(name, pat, exp_ok);
            drive(8'(px), 7'(py), c, pl);
            if (fault == F_DUP && i == fpos) drive(8'(px), 7'(py), c, 1'b1);
        end
    endtask

    task automatic drain(input string name);
        repeat (5) drive(8'd0, 7'd0, 3'b000, 1'b0);
        check(sb.size() == 0, {name, " pending_frame_done"}, sb.size(), 0);
    endtask

    initial begin
        vec_t vecs [7];
        vecs[0] = '{"drop_999",   F_DROP,   999,  0,  0, 3'b000, 0, 1'b0};
        vecs[1] = '{"good_mod6",  F_NONE,   0,    0,  0, 3'b000, 0, 1'b1};
        vecs[2] = '{"wrong_19",   F_COLOR,  0,   36, 28, 3'b001, 0, 1'b0};
        vecs[3] = '{"black_pix",  F_COLOR,  0,   60, 40, 3'b000, 1, 1'b0};
        vecs[4] = '{"clean_pat1", F_NONE,   0,    0,  0, 3'b000, 1, 1'b1};
        vecs[5] = '{"dup_2500",   F_DUP,    2500, 0,  0, 3'b000, 0, 1'b0};
        vecs[6] = '{"offnet_mix", F_OFFNET, 0,    0,  0, 3'b000, 2, 1'b1};
        for (int s = 0; s < 54; s++) model_cols[s] = 3'd7;

        repeat (3) @(posedge clk);
        #1;
        check(all_unknown(), "reset colors_all_7", int'(colors[0]), 7);
        check(frame_done == 1'b0, "reset frame_done", int'(frame_done), 0);
        check(frame_ok == 1'b0, "reset frame_ok", int'(frame_ok), 0);
        check(valid == 1'b0, "reset valid", int'(valid), 0);
        reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].name, vecs[v].pat, vecs[v].fault, vecs[v].fpos,
                       vecs[v].fx, vecs[v].fy, vecs[v].fcol, FPIX, vecs[v].exp_ok);
            drain(vecs[v].name);
        end

        // Abandoned partial frame, then a restart at (24,0) with a full frame
        send_frame("partial", 1, F_NONE, 0, 0, 0, 3'b000, 1500, 1'b0);
        send_frame("restart_full", 0, F_NONE, 0, 0, 0, 3'b000, FPIX, 1'b1);
        drain("restart_full");

        // Reset in the middle of a frame
        send_frame("pre_reset", 1, F_NONE, 0, 0, 0, 3'b000, 2000, 1'b0);
        reset = 1'b1;
        #2;
        check(all_unknown(), "midreset colors_all_7", int'(colors[1]), 7);
        check(valid == 1'b0, "midreset valid", int'(valid), 0);
        check(frame_ok == 1'b0, "midreset frame_ok", int'(frame_ok), 0);
        check(frame_done == 1'b0, "midreset frame_done", int'(frame_done), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int s = 0; s < 54; s++) model_cols[s] = 3'd7;
        model_valid = 1'b0;
        send_frame("post_reset", 1, F_NONE, 0, 0, 0, 3'b000, FPIX, 1'b1);
        drain("post_reset");

        // End pixel while idle must not evaluate anything
        drive(8'd47, 7'd71, 3'b100, 1'b1);
        drain("idle_end");
        check(frame_ok == 1'b1, "idle_end frame_ok_held", int'(frame_ok), 1);
        check(valid == 1'b1, "idle_end valid_held", int'(valid), 1);

        check(done_seen == done_exp, "total frame_done_count", done_seen, done_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cube_net_decoder.md
Name: cube_net_decoder

Overview:
- Receive end of the cube pixel-plot interface (x, y, colour, plot) driven by the cube drawer.
- Reconstructs the 54 sticker colour IDs from the drawn unfolded-net pixel stream and checks per-sticker colour consistency.
- Commits the IDs only after a complete, clean frame.
- Sits beside the drawer for closed-loop self-check and screen-state capture.

Parameters:
- STICKER_SIZE, 8, pixel edge of one sticker. Must be a power of 2; FACE_SIZE = 3*STICKER_SIZE is derived.
- FRAME_PIXELS, 3456, pixels per frame (54*STICKER_SIZE^2); derived, not overridable.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- x, input, 8, plot column.
- y, input, 7, plot row.
- colour, input, 3, RGB plot colour.
- plot, input, 1, pixel valid qualifier.
- colors, output, 3 x [0:53] (unpacked array), committed sticker IDs. Values 0..5 are colours; 7 means unknown.
- frame_done, output, 1, one-cycle pulse per evaluated frame.
- frame_ok, output, 1, result of the last evaluated frame.
- valid, output, 1, high once at least one clean frame has been committed.

Behaviour:
- Reset (async, active-high):
  - colors[*]=7, frame_done=0, frame_ok=0, valid=0.
  - Internal counters and flags cleared; FSM=IDLE.
- Pipeline:
  - Stage 1 registers x, y, colour, plot.
  - Stage 2 decodes and updates shadow state.
  - On the last frame pixel: frame_done, frame_ok and colors (if committed) update exactly 2 cycles after that pixel is presented with plot=1.
- Locate (combinational, on the registered inputs):
  - Face regions, with origin at (0,0):
    - U: x 24..47, y 0..23
    - L: x 0..23, y 24..47
    - F: x 24..47, y 24..47
    - R: x 48..71, y 24..47
    - B: x 72..95, y 24..47
    - D: x 24..47, y 48..71
  - Any other (x,y) is off-net and ignored (no state change).
  - sticker = face*9 + sy*3 + sx, where sx/sy come from the offset within the face divided by STICKER_SIZE.
  - local_x/local_y = offset mod STICKER_SIZE.
  - Implement with compares and shifts, no dividers.
- Unmap colour to ID: 100→0, 010→1, 001→2, 110→3, 011→4, 111→5; any other colour → invalid.
- FSM has two states, IDLE and CAPTURE.
  - Start pixel = plot with x=24, y=0 (sticker 0, local 0,0), accepted in any state. It clears pix_cnt (12 bit), err and the seen[53:0] bits, then processes itself as a normal pixel; state goes to CAPTURE.
  - IDLE: all pixels except the start pixel are ignored.
  - CAPTURE, for each on-net pixel:
    - pix_cnt += 1.
    - If seen[sticker]=0: store the ID in shadow[sticker] and set seen.
    - Otherwise, if the ID differs from shadow[sticker]: set err.
    - An invalid colour sets err.
  - End pixel = x=47, y=71 (sticker 53, local 7,7), processed in CAPTURE. The frame is then evaluated:
    - ok = !err && pix_cnt==FRAME_PIXELS (counting the end pixel) && all seen.
    - frame_done pulses and frame_ok=ok.
    - If ok: colors <= shadow, valid <= 1.
    - If not ok: colors hold their previous values.
    - State returns to IDLE.
- Boundary conditions:
  - plot=0 cycles are ignored.
  - Duplicate or missing pixels cause a pix_cnt mismatch, so frame_ok=0.
  - pix_cnt saturates at 4095.
  - A start pixel arriving mid-CAPTURE restarts the capture; no frame_done is produced for the abandoned frame.
  - An end pixel seen in IDLE is ignored.
  - Reset mid-frame discards all shadow state.

Decomposition:
- Package cube_pkg:
  - STICKER_SIZE, FACE_SIZE, FRAME_PIXELS.
  - Face enum U, L, F, R, B, D = 0..5, plus face origin constants.
  - Colour codes with map_color / unmap_color functions, shared with the drawer.
- Sub-module cube_pixel_locator: combinational (x,y) → on_net, sticker[5:0], local_x, local_y.

Test Plan:
- Drawer-order full frame with colors[i] = i%6 → one frame_done pulse 2 cycles after pixel (47,71); frame_ok=1; valid=1; colors[i] = i%6.
- Good frame, then a frame with pixel (36,28) colour 001 where sticker 19 is green → frame_ok=0; colors unchanged from the first frame.
- Full frame with plot held low on the 1000th pixel → pix_cnt=3455, frame_ok=0, valid stays 0.
- Frame containing one colour=000 pixel → frame_ok=0. Next clean frame → frame_ok=1.
- Reset asserted at pixel 2000 of a good frame, then one full frame → colors all 7 during reset; after the next frame, frame_ok=1.
- Off-net pixels (100,100) and (0,0) interleaved through a full frame, plus a restart pixel (24,0) mid-frame followed by a complete frame → one frame_done with frame_ok=1.
